// File: rtl/bal_seq.sv
// Balance-loop sequencer: power-up / rider-detect FSM gating the PID inputs.
// Define BAL_SEQ_WDOG_EN to build the ptch_vld watchdog and latched FAULT state.
module bal_seq #(
    parameter bit          FAST_SIM     = 1'b1,
    parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0] WT_HYST      = 13'h0040,
    parameter logic [15:0] VLD_TMO      = 16'd4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwr_req,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ptch_vld,
    output logic        pwr_up,
    output logic        rider_off,
    output logic        vld,
    output logic        en_steer,
    output logic        fault
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_IDLE   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [25:0] DB_LAST = FAST_SIM ? 26'd16383 : 26'd33554431;
    localparam logic [12:0] OFF_WT  = MIN_RIDER_WT - WT_HYST;

    logic [2:0]  state;
    logic [2:0]  nxt_state;
    logic [25:0] db_tmr;
    logic [12:0] wt_sum;
    logic        wt_on;
    logic        wt_off;
    logic        wd_expire;

    assign wt_sum = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign wt_on  = wt_sum > MIN_RIDER_WT;
    assign wt_off = wt_sum < OFF_WT;

`ifdef BAL_SEQ_WDOG_EN
    logic [15:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state != S_RUN || ptch_vld)
            wd_cnt <= '0;
        else if (wd_cnt != '1)
            wd_cnt <= wd_cnt + 16'd1;
    end

    assign wd_expire = (state == S_RUN) && !ptch_vld && (wd_cnt == VLD_TMO - 16'd1);
    assign fault     = (state == S_FAULT);
`else
    logic unused_tmo;

    assign unused_tmo = ^VLD_TMO;
    assign wd_expire  = 1'b0;
    assign fault      = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        nxt_state = state;
        case (state)
            S_OFF:    if (pwr_req) nxt_state = S_IDLE;
            S_IDLE:   if (wt_on) nxt_state = S_SETTLE;
            S_SETTLE: begin
                if (wt_off)
                    nxt_state = S_IDLE;
                else if (db_tmr == DB_LAST)
                    nxt_state = S_RUN;
            end
            S_RUN: begin
                // Rider leaving beats a simultaneous watchdog expiry.
                if (wt_off)
                    nxt_state = S_IDLE;
                else if (wd_expire)
                    nxt_state = S_FAULT;
            end
            S_FAULT:  nxt_state = S_FAULT;
            default:  nxt_state = S_OFF;
        endcase
        if (!pwr_req)
            nxt_state = S_OFF;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_OFF;
            db_tmr <= '0;
            vld    <= 1'b0;
        end else begin
            state  <= nxt_state;
            db_tmr <= (state == S_SETTLE) ? db_tmr + 26'd1 : '0;
            vld    <= ptch_vld && (state == S_RUN);
        end
    end

    assign pwr_up    = (state == S_IDLE) || (state == S_SETTLE) || (state == S_RUN);
    assign rider_off = (state != S_RUN);
    assign en_steer  = (state == S_RUN);

endmodule

// File: tb/tb_bal_seq.sv
// Scoreboard bench for bal_seq: expected outputs are queued with the edge they are due on.
// Watchdog expectations follow BAL_SEQ_WDOG_EN.
module tb_bal_seq;

    typedef struct {
        string       tag;
        int unsigned due;
        logic [4:0]  exp;
    } exp_t;

    // Output vector order: {pwr_up, rider_off, vld, en_steer, fault}
    localparam logic [4:0] O_OFF = 5'b01000;
    localparam logic [4:0] O_IDL = 5'b11000;
    localparam logic [4:0] O_RUN = 5'b10010;
    localparam logic [4:0] O_VLD = 5'b00100;
    localparam logic [4:0] O_FLT = 5'b01001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwr_req;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        ptch_vld;
    logic        pwr_up;
    logic        rider_off;
    logic        vld;
    logic        en_steer;
    logic        fault;
    logic [4:0]  outs;

    int unsigned edges = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        q[$];

    bal_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwr_req  (pwr_req),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .ptch_vld (ptch_vld),
        .pwr_up   (pwr_up),
        .rider_off(rider_off),
        .vld      (vld),
        .en_steer (en_steer),
        .fault    (fault)
    );

    assign outs = {pwr_up, rider_off, vld, en_steer, fault};

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    // Queue an expectation k edges from now, kept sorted by due edge.
    task automatic expect_out(input string tag, input int unsigned k, input logic [4:0] exp);
        exp_t e;
        int   idx;
        e.tag = tag;
        e.due = edges + k;
        e.exp = exp;
        idx   = q.size();
        while (idx > 0 && q[idx-1].due > e.due) idx--;
        q.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= edges) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, {27'd0, outs}, {27'd0, e.exp});
        end
    end

    initial begin
        rst_n    = 1'b0;
        pwr_req  = 1'b1;
        ptch_vld = 1'b0;
        set_ld(12'h000, 12'h000);
        #1;
        check("reset", {27'd0, outs}, {27'd0, O_OFF});
        tick(2);
        rst_n = 1'b1;
        expect_out("off_hold", 0, O_OFF);
        expect_out("pwr_idle", 1, O_IDL);
        tick(1);

        // Rider steps on: RUN exactly 16384 clocks after SETTLE entry.
        set_ld(12'h180, 12'h180);
        expect_out("settle_entry", 1, O_IDL);
        expect_out("settle_last", 16384, O_IDL);
        expect_out("run_entry", 16385, O_RUN);
        tick(16385);

        for (int i = 0; i < 3; i++) begin
            ptch_vld = 1'b1;
            expect_out("vld_pulse", 1, O_RUN | O_VLD);
            expect_out("vld_drop", 2, O_RUN);
            tick(1);
            ptch_vld = 1'b0;
            tick(99);
        end

        // Sum 0x1D0 sits inside the hysteresis band.
        set_ld(12'h0E8, 12'h0E8);
        expect_out("band_run", 1, O_RUN);
        expect_out("band_hold", 5, O_RUN);
        tick(5);

        // Sum 0x1B0 leaves; a pulse in the exit cycle still yields vld.
        set_ld(12'h0D8, 12'h0D8);
        ptch_vld = 1'b1;
        expect_out("drop_idle", 1, O_IDL | O_VLD);
        expect_out("drop_vld_end", 2, O_IDL);
        tick(1);
        ptch_vld = 1'b0;
        tick(1);

        // A one-clock dip mid-SETTLE restarts the full debounce.
        set_ld(12'h180, 12'h180);
        expect_out("resettle", 1, O_IDL);
        tick(1000);
        set_ld(12'h0D8, 12'h0D8);
        expect_out("glitch_idle", 1, O_IDL);
        tick(1);
        set_ld(12'h180, 12'h180);
        expect_out("restart_hold", 16384, O_IDL);
        expect_out("run_no_vld", 16385, O_RUN);
        tick(16384);
        ptch_vld = 1'b1;
        tick(1);
        ptch_vld = 1'b0;

        // Last pulse, then silence.
        tick(49);
        ptch_vld = 1'b1;
        expect_out("wd_vld", 1, O_RUN | O_VLD);
        tick(1);
        ptch_vld = 1'b0;
        expect_out("wd_before", 4095, O_RUN);
`ifdef BAL_SEQ_WDOG_EN
        expect_out("wd_fault", 4096, O_FLT);
        tick(4096);
        set_ld(12'h000, 12'h000);
        expect_out("fault_hold_lo", 1, O_FLT);
        tick(2);
        set_ld(12'h180, 12'h180);
        expect_out("fault_hold_hi", 1, O_FLT);
        tick(2);
`else
        expect_out("wd_none", 4096, O_RUN);
        tick(4096);
`endif

        ptch_vld = 1'b1;
        tick(1);
        ptch_vld = 1'b0;
        pwr_req  = 1'b0;
        expect_out("pwr_off", 1, O_OFF);
        expect_out("off_stay", 3, O_OFF);
        tick(3);

        pwr_req = 1'b1;
        set_ld(12'h180, 12'h180);
        expect_out("pwr_idle2", 1, O_IDL);
        tick(500);

        // Asynchronous reset mid-SETTLE; debounce restarts from zero.
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", {27'd0, outs}, {27'd0, O_OFF});
        tick(1);
        rst_n = 1'b1;
        expect_out("rst_off", 0, O_OFF);
        expect_out("rst_idle", 1, O_IDL);
        expect_out("rst_settle_hold", 16385, O_IDL);
        expect_out("rst_run", 16386, O_RUN);
        tick(16386);

        tick(2);
        check("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bal_seq.md
# bal_seq

Balance-loop sequencer that owns the power-up/rider-detect sequence and gates the PID controller's inputs. It sits between the inertial interface, the load-cell sampler and the PID block. It drives the PID's `pwr_up`, `rider_off` and `vld` inputs, and raises `en_steer` only once a rider has been stable on the platform for a debounce period. An optional watchdog forces a latched fault if inertial samples stop arriving while balancing.

## Interface
- `FAST_SIM`, default 1: shortens the debounce interval for simulation.
- `MIN_RIDER_WT`, default 13'h0200: summed load threshold for rider present.
- `WT_HYST`, default 13'h0040: hysteresis subtracted for the rider-leaving threshold.
- `VLD_TMO`, default 16'd4096: watchdog limit, in clocks, between `ptch_vld` pulses while in RUN.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pwr_req` input 1: level from the power switch; 1 means power requested.
- `lft_ld` input 12: left load cell, unsigned.
- `rght_ld` input 12: right load cell, unsigned.
- `ptch_vld` input 1: one-clock pulse meaning a new pitch sample is available.
- `pwr_up` output 1: to the PID soft-start timer.
- `rider_off` output 1: to the PID; clears the integrator.
- `vld` output 1: to the PID integrator enable.
- `en_steer` output 1: steering enable.
- `fault` output 1: watchdog fault, latched.

## Operation
- `wt_sum` = `lft_ld` + `rght_ld`, 13-bit unsigned, no overflow possible.
- `wt_on` = `wt_sum` > `MIN_RIDER_WT`.
- `wt_off` = `wt_sum` < (`MIN_RIDER_WT` − `WT_HYST`).
- States are OFF, IDLE, SETTLE, RUN and FAULT. Reset state is OFF.
- Global rule: `pwr_req`=0 forces the next state to OFF from any state. This has highest priority.
- OFF: `pwr_req`=1 → IDLE.
- IDLE: `wt_on` → SETTLE, with the debounce timer cleared.
- SETTLE:
  - `wt_off` → IDLE.
  - Otherwise the timer increments each clock.
  - When the timer reaches `DB_TICKS`−1 → RUN.
  - `DB_TICKS` = 2^14 if `FAST_SIM`, else 2^25. The timer is 26 bits.
  - A weight in the hysteresis band neither aborts nor pauses the timer.
- RUN:
  - `wt_off` → IDLE.
  - Else, watchdog expiry → FAULT.
  - If both occur in the same cycle, `wt_off` wins and the state goes to IDLE.
- FAULT: held until `pwr_req`=0 → OFF. Weight is ignored.
- Moore outputs, decoded from the state register:
  - `pwr_up` = 1 in IDLE, SETTLE and RUN.
  - `rider_off` = 0 only in RUN.
  - `en_steer` = 1 only in RUN.
  - `fault` = 1 only in FAULT.
- `vld` is a register loaded each clock with `ptch_vld` & (state==RUN). All other `ptch_vld` pulses are dropped.
- Watchdog counter, 16 bits:
  - Cleared when the state is not RUN, or when `ptch_vld`=1.
  - Otherwise it increments, saturating.
  - Expiry is counter == `VLD_TMO`−1 with `ptch_vld`=0 in that cycle.

## Timing
- Reset values: state OFF, `pwr_up`=0, `rider_off`=1, `vld`=0, `en_steer`=0, `fault`=0, both timers 0.
- State outputs change on the clock edge that loads the new state. There is no additional latency.
- `vld` lags `ptch_vld` by exactly 1 clock.
  - A `ptch_vld` pulse sampled in the cycle RUN is exited still produces `vld` on the next clock.
  - A pulse in the cycle RUN is entered produces no `vld`.
- Entry to RUN occurs `DB_TICKS` clocks after entry to SETTLE, provided `wt_off` never occurs in between.
- FAULT is entered `VLD_TMO` clocks after the last `ptch_vld`, or after RUN entry if no pulse has arrived since.
- `pwr_req` falling takes effect on the next edge in every state. The timers clear in OFF.
- Asserting `rst_n` mid-operation returns all outputs to their reset values immediately, asynchronously.

## Configuration
- Macro: `BAL_SEQ_WDOG_EN`.
- Defined: the watchdog counter and FAULT state are present as specified above.
- Undefined:
  - No watchdog counter is built.
  - RUN exits only via `wt_off` or `pwr_req`=0.
  - FAULT is unreachable.
  - `fault` is tied to 0.
  - `VLD_TMO` is ignored.

## Test plan
- Reset with `pwr_req`=1 and loads 0 → after 1 clock: IDLE, `pwr_up`=1, `rider_off`=1, `en_steer`=0.
- `lft_ld`=`rght_ld`=12'h180 (sum 13'h300) held, `FAST_SIM`=1 → `en_steer` and `rider_off`=0 appear exactly 16384 clocks after SETTLE entry.
- Hysteresis:
  - In RUN, drop the sum to 13'h1D0 (in band) → stays in RUN.
  - Drop it to 13'h1B0 → IDLE next clock, `rider_off`=1.
  - In SETTLE, a sum of 13'h1B0 for one clock restarts the full 16384-clock debounce.
- RUN with `ptch_vld` every 100 clocks → `vld` is a 1-clock pulse 1 clock after each. With `pwr_req`=0, `vld` and `pwr_up` go to 0 by the next edge.
- Watchdog, with `BAL_SEQ_WDOG_EN` defined:
  - Stop `ptch_vld` in RUN → `fault`=1 exactly 4096 clocks after the last pulse, with `pwr_up`=0 and `rider_off`=1.
  - The fault holds despite weight changes and clears only via `pwr_req`=0.
  - Without the macro, the same stimulus stays in RUN.
- Assert `rst_n` low mid-SETTLE → outputs reach their reset values asynchronously. After release, the debounce restarts from 0.
